// File: rtl/uart_tx_fifo.sv
// Transmit-side byte FIFO for the UART: host pushes bytes, transmitter pops with an
// active-low strobe and gets a registered head byte one cycle later.
module uart_tx_fifo #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned AFULL_LEVEL = 12
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              fifo_clr,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_n,
  output logic [WIDTH-1:0]  rd_data,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              fifo_afull,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W + 1)'(AFULL_LEVEL);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [WIDTH-1:0]  rd_data_q, rd_data_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic empty, full, pop_ok, wr_ok;

  assign empty  = (count_q == '0);
  assign full   = (count_q == DEPTH_CNT);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
  assign pop_ok = !fifo_clr && !rd_n && !empty;
  assign wr_ok  = !fifo_clr && wr_en && (!full || pop_ok);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    if (fifo_clr) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      rd_data_d = '0;
      ovf_d     = 1'b0;
      udf_d     = 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        rd_data_d = mem_q[rd_ptr_q];
      end
      unique case ({wr_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (wr_en && !wr_ok) begin
        ovf_d = 1'b1;
      end
      if (!rd_n && empty) begin
        udf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  // Storage is not reset; only locations behind valid pointers are ever read.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data    = rd_data_q;
  assign fifo_count = count_q;
  assign fifo_empty = empty;
  assign fifo_full  = full;
  assign fifo_afull = (count_q >= AFULL_CNT);
  assign overflow   = ovf_q;
  assign underflow  = udf_q;

endmodule
